toggle_checker: RTL and testbench

TOGGLE_CHECKER -- requirements
Module: toggle_checker

---
 rtl/toggle_pkg.sv | 22 ++
 rtl/toggle_lane_fsm.sv | 95 +++++++++
 rtl/toggle_checker.sv | 84 ++++++++
 tb/tb_toggle_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and helpers for the toggle checker.
// Holds the per-lane state encoding and the run-counter width helper.
// No ports; imported by toggle_lane_fsm and toggle_checker.
package toggle_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOCKED = 2'd1,
      FAIL   = 2'd2
   } lane_state_t;

   // Width needed to hold values 0..value-1, never less than one bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 16; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/toggle_lane_fsm.sv
// One monitored lane: samples the lane, flags a missed toggle, runs HUNT/LOCKED/FAIL.
// Ports: clk, rst_n (async, active-low), en, tog (lane input), locked/fail (registered),
//        fail_set (combinational strobe: lane enters FAIL on this edge).
module toggle_lane_fsm
   import toggle_pkg::*;
#(
   parameter int K_LOCK = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic tog,
   output logic locked,
   output logic fail,
   output logic fail_set
);

   localparam int RUN_W = clog2(K_LOCK);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(K_LOCK - 1);

   logic             prev;
   logic             good_q;
   logic [RUN_W-1:0] run;
   lane_state_t      state;

   // Sample and toggle detection are registered so that the FSM decision
   // on a missed toggle lands one edge after the offending sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev   <= 1'b0;
         good_q <= 1'b0;
      end else begin
         prev   <= tog;
         good_q <= tog ^ prev;
      end
   end

   // Lets the top set the sticky error on the same edge the fail pulse rises.
   assign fail_set = en && (state == LOCKED) && !good_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= HUNT;
         run    <= '0;
         locked <= 1'b0;
         fail   <= 1'b0;
      end else if (!en) begin
         // Disabled lanes restart hunting and never pulse fail.
         state  <= HUNT;
         run    <= '0;
         locked <= 1'b0;
         fail   <= 1'b0;
      end else begin
         case (state)
            HUNT: begin
               fail <= 1'b0;
               if (good_q) begin
                  if (run == RUN_MAX) begin
                     state  <= LOCKED;
                     run    <= '0;
                     locked <= 1'b1;
                  end else begin
                     run    <= run + 1'b1;
                     locked <= 1'b0;
                  end
               end else begin
                  run    <= '0;
                  locked <= 1'b0;
               end
            end
            LOCKED: begin
               if (!good_q) begin
                  state  <= FAIL;
                  locked <= 1'b0;
                  fail   <= 1'b1;
               end
            end
            FAIL: begin
               // The toggle sampled while failing is deliberately ignored.
               state  <= HUNT;
               run    <= '0;
               locked <= 1'b0;
               fail   <= 1'b0;
            end
            default: begin
               state  <= HUNT;
               run    <= '0;
               locked <= 1'b0;
               fail   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/toggle_checker.sv
// Multi-lane toggle checker: each lane must invert every cycle; lanes lock after
// K_LOCK good toggles, pulse o_fail on loss of lock, keep sticky o_err and a loss count.
// Ports: i_clk, i_rst_n (async, active-low), i_en, i_clr, i_in[K_NOUT]; outputs
//        o_locked, o_all_locked, o_fail, o_err, o_err_cnt.
// Macro TOGGLE_CHECKER_ERR_CNT_EN: when defined the saturating loss counter is built,
// otherwise o_err_cnt is tied to zero.
module toggle_checker
   import toggle_pkg::*;
#(
   parameter int K_NOUT  = 1,
   parameter int K_LOCK  = 4,
   parameter int K_CNT_W = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_clr,
   input  logic [K_NOUT-1:0]  i_in,
   output logic [K_NOUT-1:0]  o_locked,
   output logic               o_all_locked,
   output logic [K_NOUT-1:0]  o_fail,
   output logic [K_NOUT-1:0]  o_err,
   output logic [K_CNT_W-1:0] o_err_cnt
);

   logic [K_NOUT-1:0] fail_set;

   for (genvar g = 0; g < K_NOUT; g++) begin : g_lane
      toggle_lane_fsm #(
         .K_LOCK (K_LOCK)
      ) u_lane (
         .clk      (i_clk),
         .rst_n    (i_rst_n),
         .en       (i_en),
         .tog      (i_in[g]),
         .locked   (o_locked[g]),
         .fail     (o_fail[g]),
         .fail_set (fail_set[g])
      );
   end

   // Pure AND of lane lock flops, so it tracks o_locked with no extra delay.
   assign o_all_locked = &o_locked;

   // New errors win over a clear in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_err <= '0;
      end else begin
         o_err <= (i_clr ? '0 : o_err) | fail_set;
      end
   end

`ifdef TOGGLE_CHECKER_ERR_CNT_EN
   localparam int POP_W = clog2(K_NOUT + 1);
   localparam int SUM_W = K_CNT_W + POP_W;
   localparam logic [SUM_W-1:0] CNT_MAX = {{POP_W{1'b0}}, {K_CNT_W{1'b1}}};

   logic [POP_W-1:0] pop;
   logic [SUM_W-1:0] sum;

   always_comb begin
      pop = '0;
      for (int i = 0; i < K_NOUT; i++) begin
         pop = pop + POP_W'(fail_set[i]);
      end
   end

   // A clear restarts from zero but still counts losses of the same cycle.
   assign sum = {{POP_W{1'b0}}, (i_clr ? {K_CNT_W{1'b0}} : o_err_cnt)}
              + {{K_CNT_W{1'b0}}, pop};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_err_cnt <= '0;
      end else begin
         o_err_cnt <= (sum > CNT_MAX) ? CNT_MAX[K_CNT_W-1:0] : sum[K_CNT_W-1:0];
      end
   end
`else
   assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_toggle_checker.sv
// Bench for toggle_checker with two lanes, lock length 4 and a 2-bit loss counter.
// A cycle-level model of the lane rules is compared against the outputs every cycle,
// and literal expectations at key points pin the model.
module tb_toggle_checker;

   localparam int NOUT = 2;
   localparam int LOCK = 4;
   localparam int CW   = 2;
`ifdef TOGGLE_CHECKER_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam int M_HUNT = 0;
   localparam int M_LOCK = 1;
   localparam int M_FAIL = 2;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            en    = 1'b0;
   logic            clr   = 1'b0;
   logic [NOUT-1:0] din   = '0;
   logic [NOUT-1:0] cur   = '0;

   logic [NOUT-1:0] locked;
   logic            all_locked;
   logic [NOUT-1:0] fail;
   logic [NOUT-1:0] err;
   logic [CW-1:0]   err_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   toggle_checker #(
      .K_NOUT  (NOUT),
      .K_LOCK  (LOCK),
      .K_CNT_W (CW)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_en         (en),
      .i_clr        (clr),
      .i_in         (din),
      .o_locked     (locked),
      .o_all_locked (all_locked),
      .o_fail       (fail),
      .o_err        (err),
      .o_err_cnt    (err_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [NOUT-1:0] m_prev, m_gq;
   int              m_mode   [NOUT];
   int              m_streak [NOUT];
   logic [NOUT-1:0] m_locked, m_fail, m_err;
   int              m_cnt;

   always @(posedge clk or negedge rst_n) begin : upd
      logic [NOUT-1:0] fb;
      int              base;
      int              nf;
      if (!rst_n) begin
         m_prev   = '0;
         m_gq     = '0;
         m_locked = '0;
         m_fail   = '0;
         m_err    = '0;
         m_cnt    = 0;
         for (int i = 0; i < NOUT; i++) begin
            m_mode[i]   = M_HUNT;
            m_streak[i] = 0;
         end
      end else begin
         fb = '0;
         nf = 0;
         for (int i = 0; i < NOUT; i++) begin
            if (!en || m_mode[i] == M_FAIL) begin
               m_mode[i]   = M_HUNT;
               m_streak[i] = 0;
            end else if (m_mode[i] == M_LOCK) begin
               if (!m_gq[i]) begin
                  m_mode[i] = M_FAIL;
                  fb[i]     = 1'b1;
                  nf++;
               end
            end else begin
               m_streak[i] = m_gq[i] ? m_streak[i] + 1 : 0;
               if (m_streak[i] == LOCK) begin
                  m_mode[i]   = M_LOCK;
                  m_streak[i] = 0;
               end
            end
            m_locked[i] = (m_mode[i] == M_LOCK);
            m_fail[i]   = (m_mode[i] == M_FAIL);
            m_gq[i]     = (din[i] != m_prev[i]);
            m_prev[i]   = din[i];
         end
         m_err = (clr ? '0 : m_err) | fb;
         base  = clr ? 0 : m_cnt;
         if (CNT_EN) m_cnt = (base + nf > (1 << CW) - 1) ? (1 << CW) - 1 : base + nf;
         else        m_cnt = 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_locked",     locked,     m_locked);
         chk("cyc_all_locked", all_locked, &m_locked);
         chk("cyc_fail",       fail,       m_fail);
         chk("cyc_err",        err,        m_err);
         chk("cyc_err_cnt",    err_cnt,    m_cnt);
      end
   end

   // ---------------- stimulus ----------------
   // Each lane toggles unless its hold bit is set; inputs change 1 time unit after an edge.
   task automatic cyc(input logic [NOUT-1:0] hold, input logic e, input logic c);
      cur = cur ^ ~hold;
      din = cur;
      en  = e;
      clr = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3;
      chk("rst_locked",     locked,     2'b00);
      chk("rst_all_locked", all_locked, 1'b0);
      chk("rst_fail",       fail,       2'b00);
      chk("rst_err",        err,        2'b00);
      chk("rst_cnt",        err_cnt,    2'd0);
      #9;
      rst_n = 1'b1;
      en    = 1'b1;

      // Lock: first sample equals the reset prev, then four toggles.
      cyc(2'b11, 1'b1, 1'b0);
      repeat (4) cyc(2'b00, 1'b1, 1'b0);
      chk("lock_not_yet", locked, 2'b00);
      cyc(2'b00, 1'b1, 1'b0);
      chk("lock_locked",     locked,     2'b11);
      chk("lock_all_locked", all_locked, 1'b1);
      chk("lock_err",        err,        2'b00);

      // Single missed toggle on lane 1.
      repeat (3) cyc(2'b00, 1'b1, 1'b0);
      cyc(2'b10, 1'b1, 1'b0);
      chk("miss_same_edge_fail", fail,   2'b00);
      chk("miss_same_edge_lock", locked, 2'b11);
      cyc(2'b00, 1'b1, 1'b0);
      chk("miss_fail",   fail,       2'b10);
      chk("miss_locked", locked,     2'b01);
      chk("miss_all",    all_locked, 1'b0);
      chk("miss_err",    err,        2'b10);
      chk("miss_cnt",    err_cnt,    CNT_EN ? 2'd1 : 2'd0);
      cyc(2'b00, 1'b1, 1'b0);
      chk("miss_fail_end", fail, 2'b00);
      repeat (3) cyc(2'b00, 1'b1, 1'b0);
      chk("relock_not_yet", locked, 2'b01);
      cyc(2'b00, 1'b1, 1'b0);
      chk("relock", locked, 2'b11);

      // Clear alone.
      cyc(2'b00, 1'b1, 1'b1);
      chk("clr_err",    err,     2'b00);
      chk("clr_cnt",    err_cnt, 2'd0);
      chk("clr_locked", locked,  2'b11);

      // Both lanes fail on an edge carrying a clear.
      cyc(2'b11, 1'b1, 1'b0);
      cyc(2'b00, 1'b1, 1'b1);
      chk("both_fail", fail,    2'b11);
      chk("both_err",  err,     2'b11);
      chk("both_cnt",  err_cnt, CNT_EN ? 2'd2 : 2'd0);
      repeat (6) cyc(2'b00, 1'b1, 1'b0);
      chk("both_relock", locked, 2'b11);

      // Further losses saturate the 2-bit counter.
      for (int k = 0; k < 2; k++) begin
         cyc(2'b11, 1'b1, 1'b0);
         cyc(2'b00, 1'b1, 1'b0);
         repeat (6) cyc(2'b00, 1'b1, 1'b0);
      end
      chk("sat_cnt",    err_cnt, CNT_EN ? 2'd3 : 2'd0);
      chk("sat_locked", locked,  2'b11);

      // Disable for three cycles, then relock.
      cyc(2'b00, 1'b0, 1'b0);
      chk("dis_locked", locked, 2'b00);
      chk("dis_fail",   fail,   2'b00);
      repeat (2) cyc(2'b00, 1'b0, 1'b0);
      chk("dis_err_hold", err,     2'b11);
      chk("dis_cnt_hold", err_cnt, CNT_EN ? 2'd3 : 2'd0);
      repeat (3) cyc(2'b00, 1'b1, 1'b0);
      chk("en_not_yet", locked, 2'b00);
      cyc(2'b00, 1'b1, 1'b0);
      chk("en_relock", locked, 2'b11);

      // Asynchronous reset in the middle of a cycle while locked.
      cyc(2'b00, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_locked", locked,     2'b00);
      chk("arst_all",    all_locked, 1'b0);
      chk("arst_fail",   fail,       2'b00);
      chk("arst_err",    err,        2'b00);
      chk("arst_cnt",    err_cnt,    2'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("arst_hold_fail", fail, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
